// File: rtl/rs_enc_frame_ctrl_pkg.sv
// Shared types and constants for the RS(255,239) frame sequencer.
package rs_enc_frame_ctrl_pkg;

  localparam int unsigned SYM_W   = 8;
  localparam int unsigned N       = 255;
  localparam int unsigned K       = 239;
  localparam int unsigned NPAR    = N - K;
  localparam int unsigned GF_POLY = 32'h11D;
  localparam int unsigned CNT_W   = $clog2(K + 1);
  localparam int unsigned PAR_W   = $clog2(NPAR);

  typedef logic [SYM_W-1:0] sym_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  typedef struct packed {
    sym_t data;
    logic sof;
    logic last;
  } out_beat_t;

  // GF(2^8) multiply reduced by GF_POLY.
  function automatic sym_t gf_mul(input sym_t a, input sym_t b);
    sym_t p;
    sym_t x;
    sym_t y;
    p = '0;
    x = a;
    y = b;
    for (int unsigned i = 0; i < SYM_W; i++) begin
      if (y[0]) p = p ^ x;
      x = x[SYM_W-1] ? ((x << 1) ^ SYM_W'(GF_POLY)) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

endpackage

// File: rtl/rs_enc_frame_ctrl_if.sv
// Message-in and codeword-out streams of the RS frame sequencer.
interface rs_enc_frame_ctrl_if;
  import rs_enc_frame_ctrl_pkg::*;

  logic s_valid;
  logic s_ready;
  sym_t s_data;
  logic s_last;
  logic m_valid;
  logic m_ready;
  sym_t m_data;
  logic m_sof;
  logic m_last;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_sof, m_last
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_sof, m_last
  );
endinterface

// File: rtl/rs_enc_frame_ctrl_out_slot.sv
// One-deep registered valid/ready output slot for codeword beats.
module rs_enc_frame_ctrl_out_slot
  import rs_enc_frame_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      load,
  input  out_beat_t beat_in,
  input  logic      ready,
  output logic      valid,
  output out_beat_t beat,
  output logic      free_c
);

  logic      valid_q, valid_d;
  out_beat_t beat_q, beat_d;

  assign free_c = !valid_q || ready;

  // Load only ever happens when the slot is free, so it always wins.
  always_comb begin
    valid_d = valid_q;
    beat_d  = beat_q;
    if (load) begin
      valid_d = 1'b1;
      beat_d  = beat_in;
    end else if (ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      beat_q  <= '0;
    end else begin
      valid_q <= valid_d;
      beat_q  <= beat_d;
    end
  end

  assign valid = valid_q;
  assign beat  = beat_q;

endmodule

// File: rtl/rs_enc_frame_ctrl.sv
// RS(255,239) frame sequencer: feeds message symbols into the parity LFSR,
// then drains NPAR parity symbols behind them as one systematic codeword.
module rs_enc_frame_ctrl
  import rs_enc_frame_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  rs_enc_frame_ctrl_if.slave bus,
  output logic               lfsr_feed,
  output logic               lfsr_shift,
  output logic               lfsr_clr,
  input  sym_t               lfsr_msb,
  output logic               len_err
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [PAR_W-1:0] par_cnt_q, par_cnt_d;
  logic             lfsr_clr_q, lfsr_clr_d;
  logic             len_err_q, len_err_d;

  logic      slot_free_c;
  logic      load_c;
  logic      accept_c;
  logic      s_ready_c;
  logic      shift_c;
  out_beat_t beat_c;
  out_beat_t slot_beat;
  logic      slot_valid;

  rs_enc_frame_ctrl_out_slot u_out_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load_c),
    .beat_in (beat_c),
    .ready   (bus.m_ready),
    .valid   (slot_valid),
    .beat    (slot_beat),
    .free_c  (slot_free_c)
  );

  // Next-state: data beats while accepting, parity beats while draining.
  always_comb begin
    state_d    = state_q;
    sym_cnt_d  = sym_cnt_q;
    par_cnt_d  = par_cnt_q;
    lfsr_clr_d = 1'b0;
    len_err_d  = 1'b0;
    load_c     = 1'b0;
    shift_c    = 1'b0;
    beat_c     = '0;

    s_ready_c = slot_free_c && (state_q != ST_PARITY) && !lfsr_clr_q;
    accept_c  = bus.s_valid && s_ready_c;

    if (accept_c) begin
      load_c      = 1'b1;
      beat_c.data = bus.s_data;
      beat_c.sof  = (sym_cnt_q == '0);
      sym_cnt_d   = (sym_cnt_q == CNT_W'(K)) ? sym_cnt_q : sym_cnt_q + CNT_W'(1);
      if (bus.s_last) begin
        state_d = ST_PARITY;
      end else if (sym_cnt_q == CNT_W'(K - 1)) begin
        // Full-length message without a terminator: close the frame ourselves.
        state_d   = ST_PARITY;
        len_err_d = 1'b1;
      end else begin
        state_d = ST_DATA;
      end
    end else if ((state_q == ST_PARITY) && slot_free_c && !lfsr_clr_q) begin
      load_c      = 1'b1;
      shift_c     = 1'b1;
      beat_c.data = lfsr_msb;
      beat_c.last = (par_cnt_q == PAR_W'(NPAR - 1));
      par_cnt_d   = par_cnt_q + PAR_W'(1);
      if (par_cnt_q == PAR_W'(NPAR - 1)) begin
        state_d   = ST_IDLE;
        sym_cnt_d = '0;
        par_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sym_cnt_q  <= '0;
      par_cnt_q  <= '0;
      lfsr_clr_q <= 1'b1;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sym_cnt_q  <= sym_cnt_d;
      par_cnt_q  <= par_cnt_d;
      lfsr_clr_q <= lfsr_clr_d;
      len_err_q  <= len_err_d;
    end
  end

  assign bus.s_ready = s_ready_c;
  assign bus.m_valid = slot_valid;
  assign bus.m_data  = slot_beat.data;
  assign bus.m_sof   = slot_beat.sof;
  assign bus.m_last  = slot_beat.last;

  assign lfsr_feed  = accept_c;
  assign lfsr_shift = shift_c;
  assign lfsr_clr   = lfsr_clr_q;
  assign len_err    = len_err_q;

endmodule

// File: tb/tb_rs_enc_frame_ctrl.sv
// Scoreboard bench for rs_enc_frame_ctrl with a behavioural parity LFSR.
module tb_rs_enc_frame_ctrl;
  import rs_enc_frame_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rs_enc_frame_ctrl_if bus ();
  logic lfsr_feed, lfsr_shift, lfsr_clr, len_err;
  sym_t lfsr_msb;

  rs_enc_frame_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .lfsr_feed  (lfsr_feed),
    .lfsr_shift (lfsr_shift),
    .lfsr_clr   (lfsr_clr),
    .lfsr_msb   (lfsr_msb),
    .len_err    (len_err)
  );

  int        n_vec = 0;
  int        n_err = 0;
  out_beat_t exp_q[$];
  out_beat_t mon_e;
  sym_t      gcoef [NPAR+1];
  sym_t      msg [K];
  sym_t      lfsr_r [NPAR];
  sym_t      lfsr_fb;
  int        beats_seen  = 0;
  int        len_err_cnt = 0;
  bit        par_window  = 0;
  bit        rand_ready  = 0;
  bit        stall_v     = 0;
  out_beat_t stall_b;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h @%0t", name, act, req, $time);
    end
  endtask

  // g(x) = prod_{i=0..15} (x + alpha^i), alpha = 0x02.
  task automatic gen_poly();
    sym_t a;
    a = 8'h01;
    for (int i = 0; i <= NPAR; i++) gcoef[i] = '0;
    gcoef[0] = 8'h01;
    for (int i = 0; i < NPAR; i++) begin
      for (int j = NPAR; j >= 1; j--) gcoef[j] = gcoef[j-1] ^ gf_mul(gcoef[j], a);
      gcoef[0] = gf_mul(gcoef[0], a);
      a = gf_mul(a, 8'h02);
    end
  endtask

  // External parity LFSR stand-in.
  assign lfsr_fb  = bus.s_data ^ lfsr_r[NPAR-1];
  assign lfsr_msb = lfsr_r[NPAR-1];
  always @(posedge clk) begin
    if (lfsr_clr) begin
      for (int i = 0; i < NPAR; i++) lfsr_r[i] <= '0;
    end else if (lfsr_feed) begin
      for (int i = NPAR - 1; i > 0; i--) lfsr_r[i] <= lfsr_r[i-1] ^ gf_mul(lfsr_fb, gcoef[i]);
      lfsr_r[0] <= gf_mul(lfsr_fb, gcoef[0]);
    end else if (lfsr_shift) begin
      for (int i = NPAR - 1; i > 0; i--) lfsr_r[i] <= lfsr_r[i-1];
      lfsr_r[0] <= '0;
    end
  end

  // Expected codeword: message, then m(x)*x^16 mod g(x) by long division.
  task automatic push_frame(input int n, input bit gen_par);
    sym_t      b [K+NPAR];
    sym_t      c;
    out_beat_t e;
    for (int i = 0; i < K + NPAR; i++) b[i] = (i < n) ? msg[i] : 8'h00;
    for (int i = 0; i < n; i++) begin
      c = b[i];
      for (int j = 1; j <= NPAR; j++) b[i+j] = b[i+j] ^ gf_mul(c, gcoef[NPAR-j]);
    end
    for (int i = 0; i < n; i++) begin
      e.data = msg[i]; e.sof = (i == 0); e.last = 1'b0;
      exp_q.push_back(e);
    end
    for (int j = 0; j < NPAR; j++) begin
      e.data = gen_par ? gcoef[NPAR-1-j] : b[n+j];
      e.sof  = 1'b0;
      e.last = (j == NPAR - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_frame(input int n, input bit set_last, input bit bubbles, output int first_wait);
    int cnt;
    bit accepted;
    first_wait = 0;
    for (int i = 0; i < n; i++) begin
      if (bubbles && ($urandom_range(0, 2) == 0)) begin
        bus.s_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.s_valid = 1'b1;
      bus.s_data  = msg[i];
      bus.s_last  = set_last && (i == n - 1);
      cnt = 0;
      accepted = 0;
      while (!accepted) begin
        @(negedge clk);
        if (bus.s_ready) accepted = 1;
        else cnt++;
        @(posedge clk); #1;
        if (!accepted && cnt > 1000) begin
          n_vec++; n_err++;
          $display("FAIL accept_timeout: symbol %0d not accepted within %0d cycles", i, cnt);
          accepted = 1;
        end
      end
      if (i == 0) first_wait = cnt;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    par_window  = 1'b1;
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    while (exp_q.size() > 0 && cnt < 5000) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (exp_q.size() > 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    bus.m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor / scoreboard.
  always @(negedge clk) begin
    if (stall_v) begin
      chk("stall_valid", int'(bus.m_valid), 1);
      chk("stall_hold", int'({bus.m_data, bus.m_sof, bus.m_last}), int'(stall_b));
    end
    stall_v = bus.m_valid && !bus.m_ready;
    stall_b = {bus.m_data, bus.m_sof, bus.m_last};
    chk("feed_shift_excl", int'(lfsr_feed && lfsr_shift), 0);
    if (lfsr_clr) chk("clr_quiet", int'(lfsr_feed || lfsr_shift), 0);
    if (par_window && !(bus.m_valid && bus.m_last)) chk("s_ready_parity", int'(bus.s_ready), 0);
    if (len_err) len_err_cnt++;
    if (bus.m_valid && bus.m_ready) begin
      beats_seen++;
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL extra_beat: got data 0x%0h, required no beat", bus.m_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("m_data", int'(bus.m_data), int'(mon_e.data));
        chk("m_sof", int'(bus.m_sof), int'(mon_e.sof));
        chk("m_last", int'(bus.m_last), int'(mon_e.last));
      end
      if (bus.m_last) par_window = 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fw, bw, le;
    gen_poly();
    rst_n = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", int'(bus.m_valid), 0);
    chk("rst_m_sof", int'(bus.m_sof), 0);
    chk("rst_m_last", int'(bus.m_last), 0);
    chk("rst_len_err", int'(len_err), 0);
    chk("rst_lfsr_clr", int'(lfsr_clr), 1);
    chk("rst_s_ready", int'(bus.s_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rel_lfsr_clr", int'(lfsr_clr), 0);
    chk("rel_s_ready", int'(bus.s_ready), 1);
    @(posedge clk); #1;

    // 1: all-zero full frame
    for (int i = 0; i < K; i++) msg[i] = 8'h00;
    bw = beats_seen; le = len_err_cnt;
    push_frame(K, 0);
    send_frame(K, 1, 0, fw);
    drain();
    chk("t1_beats", beats_seen - bw, N);
    chk("t1_len_err", len_err_cnt - le, 0);

    // 2: m(x)=1 yields the generator tail as parity
    msg[K-1] = 8'h01;
    le = len_err_cnt;
    push_frame(K, 1);
    send_frame(K, 1, 0, fw);
    drain();
    chk("t2_len_err", len_err_cnt - le, 0);

    // 3: shortened frames back to back
    bw = beats_seen;
    for (int i = 0; i < 10; i++) msg[i] = 8'($urandom);
    push_frame(10, 0);
    send_frame(10, 1, 0, fw);
    chk("t3_first_wait", fw, 0);
    for (int i = 0; i < 10; i++) msg[i] = 8'($urandom);
    push_frame(10, 0);
    send_frame(10, 1, 0, fw);
    chk("t3_b2b_wait", fw, NPAR);
    drain();
    chk("t3_beats", beats_seen - bw, 2 * (10 + NPAR));

    // 4: K symbols without s_last
    for (int i = 0; i < K; i++) msg[i] = 8'($urandom);
    le = len_err_cnt;
    push_frame(K, 0);
    send_frame(K, 0, 0, fw);
    drain();
    chk("t4_len_err", len_err_cnt - le, 1);

    // 5: random backpressure and input bubbles
    rand_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      int n;
      n = (f == 0) ? 37 : (f == 1) ? 1 : (f == 2) ? 5 : 64;
      for (int i = 0; i < n; i++) msg[i] = 8'($urandom);
      push_frame(n, 0);
      send_frame(n, 1, 1, fw);
    end
    drain();
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 6: reset while parity beat 5 is presented
    for (int i = 0; i < 20; i++) msg[i] = 8'($urandom);
    bw = beats_seen;
    push_frame(20, 0);
    send_frame(20, 1, 0, fw);
    fw = 0;
    while (beats_seen - bw < 24 && fw < 1000) begin
      @(posedge clk); #1;
      fw++;
    end
    chk("t6_reach_par5", int'(beats_seen - bw >= 24), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    par_window = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_m_valid", int'(bus.m_valid), 0);
    chk("t6_lfsr_clr", int'(lfsr_clr), 1);
    chk("t6_s_ready", int'(bus.s_ready), 0);
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) msg[i] = 8'($urandom);
    bw = beats_seen;
    push_frame(12, 0);
    send_frame(12, 1, 0, fw);
    drain();
    chk("t6_beats", beats_seen - bw, 12 + NPAR);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
